// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU operation classes and datapath mux selects.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBeq,
        StJal,
        StTrap
    } state_e;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIAlu  = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decode: maps the FSM's ALU operation class and the
// instruction's funct fields onto an ALUControl code.
module mc_alu_dec
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = AluAdd;
        case (alu_op)
            AluOpSub: alu_control = AluSub;
            AluOpFunct: begin
                case (funct3)
                    // op5 separates R-type sub from addi, whose imm may set bit 30
                    3'b000:  alu_control = (op5 && funct7b5) ? AluSub : AluAdd;
                    3'b010:  alu_control = AluSlt;
                    3'b110:  alu_control = AluOr;
                    3'b111:  alu_control = AluAnd;
                    default: alu_control = AluAdd;
                endcase
            end
            default: alu_control = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencer: Moore-decoded datapath controls, memory
// request/ready handshake, immediate-format decode and a retired-instruction counter.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [1:0]       ImmSrc,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic [1:0]       alu_op;
    logic [CNT_W-1:0] instret_q;
    logic             ready;

    // While reset is held the outputs must look like an idle FETCH.
    assign ready   = mem_ready & reset;
    assign instret = instret_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = ResAluOut;
        ALUSrcA   = SrcAPc;
        ALUSrcB   = SrcBRs2;
        alu_op    = AluOpAdd;
        retire    = 1'b0;
        illegal   = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_req   = 1'b1;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAluResult;
                IRWrite   = ready;
                PCWrite   = ready;
                if (ready) state_d = StDecode;
            end
            StDecode: begin
                ALUSrcA = SrcAOldPc;
                ALUSrcB = SrcBImm;
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIAlu:          state_d = StExecI;
                    OpBeq:           state_d = StBeq;
                    OpJal:           state_d = StJal;
                    default:         state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = SrcARs1;
                ALUSrcB = SrcBImm;
                state_d = (op == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (ready) state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc = ResData;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StMemWrite: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                retire   = ready;
                if (ready) state_d = StFetch;
            end
            StExecR: begin
                ALUSrcA = SrcARs1;
                alu_op  = AluOpFunct;
                state_d = StAluWb;
            end
            StExecI: begin
                ALUSrcA = SrcARs1;
                ALUSrcB = SrcBImm;
                alu_op  = AluOpFunct;
                state_d = StAluWb;
            end
            StAluWb: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StBeq: begin
                ALUSrcA = SrcARs1;
                alu_op  = AluOpSub;
                PCWrite = Zero;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StJal: begin
                ALUSrcA = SrcAOldPc;
                ALUSrcB = SrcBFour;
                PCWrite = 1'b1;
                state_d = StAluWb;
            end
            StTrap: illegal = 1'b1;
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        case (op)
            OpStore: ImmSrc = ImmS;
            OpBeq:   ImmSrc = ImmB;
            OpJal:   ImmSrc = ImmJ;
            default: ImmSrc = ImmI;
        endcase
    end

    mc_alu_dec u_alu_dec (
        .alu_op     (alu_op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .alu_control(ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle scripts built from the
// instruction-level rules, random wait states, plus reset and counter-wrap cases.
module tb_multicycle_controller;

    typedef struct packed {
        logic       req, mw, adr, irw, pcw, rw;
        logic [1:0] rs, sa, sb;
        logic [2:0] alu;
        logic       ret, ill;
    } ctl_t;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1110011;

    logic        clk, reset, funct7b5, Zero, mem_ready;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, retire, illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUControl;
    logic [31:0] instret;
    // Narrow-counter instance: same stimulus, used to observe modulo wrap.
    logic        n_req, n_mw, n_adr, n_irw, n_pcw, n_rw, n_ret, n_ill;
    logic [1:0]  n_rs, n_sa, n_sb, n_imm;
    logic [2:0]  n_alu, n_instret;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cnt = 0;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .retire(retire), .instret(instret),
        .illegal(illegal)
    );

    multicycle_controller #(.CNT_W(3)) dut_w (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .mem_req(n_req), .MemWrite(n_mw),
        .AdrSrc(n_adr), .IRWrite(n_irw), .PCWrite(n_pcw), .RegWrite(n_rw),
        .ResultSrc(n_rs), .ALUSrcA(n_sa), .ALUSrcB(n_sb), .ALUControl(n_alu),
        .ImmSrc(n_imm), .retire(n_ret), .instret(n_instret), .illegal(n_ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t mk(input logic req, mw, adr, irw, pcw, rw,
                                input logic [1:0] rs, sa, sb, input logic [2:0] alu,
                                input logic ret);
        ctl_t c;
        c = '{req: req, mw: mw, adr: adr, irw: irw, pcw: pcw, rw: rw, rs: rs, sa: sa,
              sb: sb, alu: alu, ret: ret, ill: 1'b0};
        return c;
    endfunction

    // A memory step that is still waiting: no loads, no retirement yet.
    function automatic ctl_t waiting(input ctl_t c);
        ctl_t w = c;
        w.irw = 1'b0;
        w.pcw = 1'b0;
        w.ret = 1'b0;
        return w;
    endfunction

    function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] f3,
                                           input logic f7);
        case (f3)
            3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] imm_ref(input logic [6:0] o);
        if (o == OP_SW) return 2'b01;
        if (o == OP_BEQ) return 2'b10;
        if (o == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic ctl_t fetch_w();
        return mk(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
    endfunction
    function automatic ctl_t decode_w();
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0);
    endfunction
    function automatic ctl_t adr_w();
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    endfunction
    function automatic ctl_t store_w();
        return mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1);
    endfunction
    function automatic ctl_t wb_w();
        return mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 1);
    endfunction

    task automatic check_ctl(input ctl_t e);
        ctl_t obs;
        obs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ALUControl, retire, illegal};
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL ctl op=%b observed=%h expected=%h", op, obs, e);
        end
        checks++;
        assert (ImmSrc === imm_ref(op)) else begin
            errors++;
            $error("FAIL immsrc op=%b observed=%b expected=%b", op, ImmSrc, imm_ref(op));
        end
        checks++;
        assert (instret === exp_cnt) else begin
            errors++;
            $error("FAIL instret observed=%0d expected=%0d", instret, exp_cnt);
        end
        checks++;
        assert (n_instret === exp_cnt[2:0]) else begin
            errors++;
            $error("FAIL instret_wrap observed=%0d expected=%0d", n_instret, exp_cnt[2:0]);
        end
    endtask

    // One script step: optional stall cycles, then the completing cycle.
    task automatic do_step(input ctl_t e, input logic is_mem, input int waits);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1 check_ctl(waiting(e));
        end
        @(negedge clk);
        mem_ready = is_mem ? 1'b1 : 1'($urandom_range(0, 1));
        #1 check_ctl(e);
        if (e.ret) exp_cnt++;
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw);
        ctl_t t;
        op = o;
        funct3 = f3;
        funct7b5 = f7;
        Zero = z;
        do_step(fetch_w(), 1, fw);
        do_step(decode_w(), 0, 0);
        case (o)
            OP_LW: begin
                do_step(adr_w(), 0, 0);
                do_step(mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0), 1, mw);
                do_step(mk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 1), 0, 0);
            end
            OP_SW: begin
                do_step(adr_w(), 0, 0);
                do_step(store_w(), 1, mw);
            end
            OP_R, OP_I: begin
                do_step(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, (o == OP_I) ? 2'b01 : 2'b00,
                           alu_ref(o, f3, f7), 0), 0, 0);
                do_step(wb_w(), 0, 0);
            end
            OP_BEQ: do_step(mk(0, 0, 0, 0, z, 0, 2'b00, 2'b10, 2'b00, 3'b001, 1), 0, 0);
            OP_JAL: begin
                do_step(mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0), 0, 0);
                do_step(wb_w(), 0, 0);
            end
            default: begin
                t = '0;
                t.ill = 1'b1;
                for (int i = 0; i < 10; i++) do_step(t, 0, 0);
            end
        endcase
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        mem_ready = 1'b1;
        exp_cnt = 0;
        #1 check_ctl(waiting(fetch_w()));
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        logic [6:0] ops [6];
        ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
        op = OP_R;
        funct3 = 3'b000;
        funct7b5 = 1'b0;
        Zero = 1'b0;
        @(negedge clk);
        pulse_reset();

        run_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(OP_R, 3'b000, 1'b1, 1'b0, 0, 0);
        run_instr(OP_I, 3'b000, 1'b1, 1'b0, 1, 0);
        run_instr(OP_R, 3'b010, 1'b0, 1'b0, 0, 0);
        run_instr(OP_I, 3'b110, 1'b0, 1'b0, 0, 0);
        run_instr(OP_R, 3'b111, 1'b0, 1'b0, 0, 0);
        run_instr(OP_LW, 3'b010, 1'b0, 1'b0, 0, 3);
        run_instr(OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr(OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(OP_SW, 3'b010, 1'b0, 1'b0, 2, 1);

        for (int n = 0; n < 60; n++)
            run_instr(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3));

        run_instr(OP_BAD, 3'b000, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        pulse_reset();
        run_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0);

        // Reset lands while a store is still waiting for memory.
        op = OP_SW;
        do_step(fetch_w(), 1, 0);
        do_step(decode_w(), 0, 0);
        do_step(adr_w(), 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1 check_ctl(waiting(store_w()));
        end
        pulse_reset();
        run_instr(OP_I, 3'b111, 1'b0, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multicycle RV32I core variant, which shares one ALU and one unified instruction/data memory across cycles.
- Takes the opcode and funct fields latched in the instruction register, plus the ALU Zero flag.
- Emits per-cycle datapath enables and multiplexer selects, plus a memory request/ready handshake.
- Replaces the single-cycle decode path when the core is built multicycle; also provides an instruction-retired counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-low reset.
- op  input  7  opcode field from the instruction register.
- funct3  input  3  funct3 from the instruction register.
- funct7b5  input  1  bit 30 of the instruction register.
- Zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completed the current access this cycle.
- mem_req  output  1  memory access request.
- MemWrite  output  1  the access is a write.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  output  1  load the instruction register and OldPC.
- PCWrite  output  1  load the PC.
- RegWrite  output  1  register file write.
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  output  2  00 = rs2, 01 = imm, 10 = constant 4.
- ALUControl  output  3  ALU operation.
- ImmSrc  output  2  00 = I, 01 = S, 10 = B, 11 = J.
- retire  output  1  one-cycle pulse when an instruction completes.
- instret  output  CNT_W  retired-instruction count.
- illegal  output  1  core halted on an unsupported opcode.

Behaviour:
- Reset: state = FETCH, instret = 0. Outputs are Moore-decoded from state, so during reset they show FETCH values with mem_ready treated as 0: mem_req=1, all enables 0.
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- States and outputs (signals not listed are 0 / 00):
  - FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite = mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state: lw/sw→MEMADR, R→EXECUTER, I-ALU→EXECUTEI, beq→BEQ, jal→JAL, any other opcode→TRAP.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state: lw→MEMREAD, sw→MEMWRITE.
  - MEMREAD: mem_req=1, AdrSrc=1. Stall until mem_ready, then go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, retire=1. Next state FETCH.
  - MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1. Stall until mem_ready; retire = mem_ready; then go to FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, retire=1. Next state FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero, retire=1. Next state FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Next state ALUWB, which writes PC+4 to rd.
  - TRAP: illegal=1, mem_req=0, all enables 0. Absorbing; only reset leaves it.
- ALU decode:
  - ALUOp 00 → add (000).
  - ALUOp 01 → sub (001).
  - ALUOp 10 → by funct3: 000 = sub only when {op[5], funct7b5} = 11, otherwise add; 010 = slt (101); 110 = or (011); 111 = and (010).
  - Other funct3 values in ALUOp 10 → add.
- ImmSrc is combinational from op in every state: lw/I-ALU→00, sw→01, beq→10, jal→11, others→00.
- Memory handshake:
  - mem_req must stay high with AdrSrc and MemWrite stable until the cycle mem_ready=1.
  - mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
  - mem_ready may be high in the first request cycle, giving zero wait states.
- instret increments by 1 on each retire cycle and wraps modulo 2^CNT_W. It does not increment in TRAP.
- Reset asserted mid-instruction: state returns to FETCH immediately (asynchronously) and instret clears. No partial write may be retired afterwards.
- Latency with zero wait states: R/I = 4 cycles, lw = 5, sw = 4, beq = 3, jal = 4.

Decomposition:
- Shared package: state enum (FETCH…TRAP), opcode constants, ALUOp and ALUControl encodings, ResultSrc/ALUSrc encodings.
- One sub-module, mc_alu_dec (combinational): ALUOp, funct3, funct7b5, op[5] → ALUControl.
- The FSM, ImmSrc decode and instret counter stay in the top module.

Test Plan:
- add (op 0110011, f3 000, f7b5 0), mem_ready=1 → states FETCH, DECODE, EXECUTER, ALUWB; ALUControl=000 in EXECUTER; RegWrite=1 and retire=1 in cycle 4; instret=1.
- lw with mem_ready held low for 3 cycles in MEMREAD → mem_req=1 and AdrSrc=1 held stable for 4 cycles; MEMWB follows with ResultSrc=01 and RegWrite=1; total 8 cycles.
- beq with Zero=1, then beq with Zero=0 → PCWrite=1 / 0 respectively in the BEQ state; retire=1 in both; ImmSrc=10.
- jal → JAL state has PCWrite=1; ALUWB state has RegWrite=1 and ResultSrc=00; ImmSrc=11; 4 cycles.
- op=1110011 (unsupported) → DECODE→TRAP; illegal=1 and mem_req=0 for 10 cycles; reset low then high → FETCH, illegal=0.
- Reset pulsed during MEMWRITE wait → outputs immediately show FETCH values, instret=0, no retire pulse seen; preload instret=2^32−1 then retire once → instret=0.
